// File: rtl/pool_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pool_scheduler
// Description : Frame-granular time-sharing of one max-pool unit between two
//               pixel requesters. A requester is granted a whole frame: its
//               IMAGE_HEIGHT*IMAGE_WIDTH input beats are steered to the pool
//               unit, and the pool results are forwarded to the consumer
//               tagged with the owning requester. Grants alternate between
//               requesters when both are waiting.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i             rising-edge clock
//   reset_ni          asynchronous active-low reset
//   req_valid_i[1:0]  requester has a pixel beat
//   req_ready_o[1:0]  requester beat accepted (owner only)
//   req_data_i[1:0]   requester pixels
//   pool_in_*         beat stream to the shared max-pool unit
//   pool_out_*        result stream from the max-pool unit
//   out_*             result stream to the consumer
//   out_owner_o       requester index of the current result
//   busy_o            frame in progress
//   frame_done_o      one-cycle pulse after a frame completes
//   done_owner_o      owner of the last completed frame
//   overrun_o         sticky: pool result seen when none was expected
// ============================================================================
module pool_scheduler #(
  parameter int IMAGE_HEIGHT  = 4,
  parameter int IMAGE_WIDTH   = 4,
  parameter int ROW_STRIDE    = 2,
  parameter int COL_STRIDE    = 2,
  parameter int FEATURE_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  // requesters
  input  logic [1:0]                    req_valid_i,
  output logic [1:0]                    req_ready_o,
  input  logic [1:0][FEATURE_WIDTH-1:0] req_data_i,
  // shared max-pool unit, input side
  output logic                          pool_in_valid_o,
  input  logic                          pool_in_ready_i,
  output logic [FEATURE_WIDTH-1:0]      pool_in_data_o,
  // shared max-pool unit, result side
  input  logic                          pool_out_valid_i,
  output logic                          pool_out_ready_o,
  input  logic [FEATURE_WIDTH-1:0]      pool_out_data_i,
  // consumer
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [FEATURE_WIDTH-1:0]      out_data_o,
  output logic                          out_owner_o,
  // status
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          done_owner_o,
  output logic                          overrun_o
);

  localparam int IN_BEATS  = IMAGE_HEIGHT * IMAGE_WIDTH;
  localparam int OUT_BEATS = (IMAGE_HEIGHT / ROW_STRIDE) * (IMAGE_WIDTH / COL_STRIDE);
  localparam int IN_CW     = $clog2(IN_BEATS + 1);
  localparam int OUT_CW    = $clog2(OUT_BEATS + 1);

  localparam logic [IN_CW-1:0]  IN_LAST   = IN_CW'(IN_BEATS - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST  = OUT_CW'(OUT_BEATS - 1);
  localparam logic [OUT_CW-1:0] OUT_TOTAL = OUT_CW'(OUT_BEATS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;
  logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                done_owner_q, done_owner_d;
  logic                overrun_q, overrun_d;

  logic                out_full;
  logic                in_fire;
  logic                out_fire;
  logic                in_done;
  logic                out_done;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      prio_q       <= 1'b0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      done_owner_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      prio_q       <= prio_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frame_done_q <= frame_done_d;
      done_owner_q <= done_owner_d;
      overrun_q    <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    prio_d           = prio_q;
    in_cnt_d         = in_cnt_q;
    out_cnt_d        = out_cnt_q;
    frame_done_d     = 1'b0;
    done_owner_d     = done_owner_q;
    overrun_d        = overrun_q;

    req_ready_o      = 2'b00;
    pool_in_valid_o  = 1'b0;
    pool_in_data_o   = '0;
    pool_out_ready_o = 1'b0;
    out_valid_o      = 1'b0;
    out_data_o       = '0;

    // Once every result of the frame has been taken, the result path is
    // closed so a surplus beat can never reach the consumer.
    out_full = (out_cnt_q == OUT_TOTAL);
    in_fire  = 1'b0;
    out_fire = 1'b0;
    in_done  = 1'b0;
    out_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Grant goes to the priority requester when it is waiting,
        // otherwise to whichever one is.
        if (|req_valid_i) begin
          owner_d   = req_valid_i[prio_q] ? prio_q : ~prio_q;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = S_FEED;
        end
      end

      S_FEED, S_DRAIN: begin
        if (state_q == S_FEED) begin
          pool_in_valid_o       = req_valid_i[owner_q];
          pool_in_data_o        = req_data_i[owner_q];
          req_ready_o[owner_q]  = pool_in_ready_i;
          in_fire               = req_valid_i[owner_q] && pool_in_ready_i;
        end

        out_data_o = pool_out_data_i;
        if (!out_full) begin
          out_valid_o      = pool_out_valid_i;
          pool_out_ready_o = out_ready_i;
          out_fire         = pool_out_valid_i && out_ready_i;
        end

        if (in_fire) begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
        if (out_fire) begin
          out_cnt_d = out_cnt_q + 1'b1;
        end

        // "Done" includes the beat completing on this very edge, so input
        // and output sides finishing together retire the frame at once.
        in_done  = (state_q == S_DRAIN) || (in_fire && (in_cnt_q == IN_LAST));
        out_done = out_full || (out_fire && (out_cnt_q == OUT_LAST));

        if (in_done && out_done) begin
          state_d      = S_IDLE;
          in_cnt_d     = '0;
          out_cnt_d    = '0;
          prio_d       = ~owner_q;
          frame_done_d = 1'b1;
          done_owner_d = owner_q;
        end else if (in_done) begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d   = S_IDLE;
        in_cnt_d  = '0;
        out_cnt_d = '0;
      end
    endcase

    // A pool result with no frame to attribute it to is a protocol error.
    if (pool_out_valid_i && ((state_q == S_IDLE) || out_full)) begin
      overrun_d = 1'b1;
    end
  end

  assign out_owner_o  = owner_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = frame_done_q;
  assign done_owner_o = done_owner_q;
  assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_scheduler
// Description : Self-checking bench for pool_scheduler. Emulates the shared
//               2x2/stride-2 max-pool unit and two requesters; expected
//               results are pushed to a scoreboard when frames are loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_scheduler;

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][7:0]  req_data_i;
  logic             pool_in_valid_o;
  logic             pool_in_ready_i;
  logic [7:0]       pool_in_data_o;
  logic             pool_out_valid_i;
  logic             pool_out_ready_o;
  logic [7:0]       pool_out_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [7:0]       out_data_o;
  logic             out_owner_o;
  logic             busy_o;
  logic             frame_done_o;
  logic             done_owner_o;
  logic             overrun_o;

  always #5 clk_i = ~clk_i;

  pool_scheduler #(
    .IMAGE_HEIGHT (4),
    .IMAGE_WIDTH  (4),
    .ROW_STRIDE   (2),
    .COL_STRIDE   (2),
    .FEATURE_WIDTH(8)
  ) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_data_i      (req_data_i),
    .pool_in_valid_o (pool_in_valid_o),
    .pool_in_ready_i (pool_in_ready_i),
    .pool_in_data_o  (pool_in_data_o),
    .pool_out_valid_i(pool_out_valid_i),
    .pool_out_ready_o(pool_out_ready_o),
    .pool_out_data_i (pool_out_data_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_data_o      (out_data_o),
    .out_owner_o     (out_owner_o),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .done_owner_o    (done_owner_o),
    .overrun_o       (overrun_o)
  );

  // Frames (first pixel in the MSB byte) and their 2x2 max-pool results.
  localparam logic [127:0] F0 = {8'd8, 8'd1, 8'd5, 8'd3, 8'd6, 8'd7, 8'd2, 8'd4,
                                 8'd9, 8'd0, 8'd3, 8'd2, 8'd1, 8'd5, 8'd6, 8'd8};
  localparam logic [31:0]  E0 = {8'd8, 8'd5, 8'd9, 8'd8};
  localparam logic [127:0] F1 = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                                 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
  localparam logic [31:0]  E1 = {8'd5, 8'd7, 8'd13, 8'd15};
  localparam logic [127:0] F2 = {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8,
                                 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [31:0]  E2 = {8'd15, 8'd13, 8'd7, 8'd5};
  localparam logic [127:0] F3 = {8'd200, 8'd3, 8'd7, 8'd255, 8'd1, 8'd2, 8'd250, 8'd9,
                                 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd128, 8'd64};
  localparam logic [31:0]  E3 = {8'd200, 8'd255, 8'd1, 8'd128};

  typedef struct packed {
    logic         r;
    logic         gap;
    logic         tog;
    logic [127:0] pix;
    logic [31:0]  ex;
  } frow_t;

  typedef struct packed {
    logic [1:0] rv;
    logic       pir;
    logic       pov;
    logic       ordy;
    logic [5:0] ex;   // {req_ready, pool_in_valid, pool_out_ready, out_valid, busy}
  } ivec_t;

  frow_t      ftab [4];
  ivec_t      itab [4];

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  logic [7:0] rq0 [$];
  logic [7:0] rq1 [$];
  logic [8:0] sb  [$];
  logic       done_q [$];
  logic [7:0] pq  [$];
  logic [7:0] pbuf [16];
  int         pcnt;
  int         fin_cnt;
  int         fout_cnt;
  logic       prev_fd;
  logic       gap_en;
  logic       tog_en;
  logic       pov_force;
  logic       exp_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    logic g;
    g = gap_en && ((cyc % 2) == 1);
    req_valid_i[0]   = (rq0.size() > 0) && !g;
    req_data_i[0]    = (rq0.size() > 0) ? rq0[0] : 8'h00;
    req_valid_i[1]   = (rq1.size() > 0) && !g;
    req_data_i[1]    = (rq1.size() > 0) ? rq1[0] : 8'h00;
    pool_in_ready_i  = 1'b1;
    pool_out_valid_i = pov_force || (pq.size() > 0);
    pool_out_data_i  = (pq.size() > 0) ? pq[0] : 8'h00;
    out_ready_i      = tog_en ? ((cyc % 2) == 0) : 1'b1;
  endtask

  task automatic load(input logic r, input logic [127:0] pix, input logic [31:0] ex);
    logic [7:0] px;
    for (int i = 0; i < 16; i++) begin
      px = pix[127-8*i -: 8];
      if (r) rq1.push_back(px);
      else   rq0.push_back(px);
    end
    for (int k = 0; k < 4; k++) sb.push_back({r, ex[31-8*k -: 8]});
    done_q.push_back(r);
  endtask

  // One clock: sample and check at the falling edge, update inputs after
  // the rising edge.
  task automatic step();
    logic       f0, f1;
    logic [7:0] ed, m, v;
    logic [8:0] e;
    @(negedge clk_i);
    f0 = req_valid_i[0] && req_ready_o[0];
    f1 = req_valid_i[1] && req_ready_o[1];
    if (busy_o && done_q.size() > 0)
      check("nonowner_ready", {31'd0, req_ready_o[!done_q[0]]}, 32'd0);
    if (pool_in_valid_o && pool_in_ready_i) begin
      check("in_src_count", 32'(f0) + 32'(f1), 32'd1);
      ed = f0 ? ((rq0.size() > 0) ? rq0[0] : 8'h00) : ((rq1.size() > 0) ? rq1[0] : 8'h00);
      check("in_data", {24'd0, pool_in_data_o}, {24'd0, ed});
      pbuf[pcnt] = pool_in_data_o;
      pcnt++;
      fin_cnt++;
      if (pcnt == 16) begin
        for (int k = 0; k < 4; k++) begin
          m = 8'h00;
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
              v = pbuf[(2*(k/2)+i)*4 + 2*(k%2) + j];
              if (v > m) m = v;
            end
          pq.push_back(m);
        end
        pcnt = 0;
      end
    end else if (f0 || f1) begin
      check("req_fire_no_pool_beat", {30'd0, f1, f0}, 32'd0);
    end
    if (f0 && rq0.size() > 0) void'(rq0.pop_front());
    if (f1 && rq1.size() > 0) void'(rq1.pop_front());
    if (pool_out_valid_i && pool_out_ready_o && pq.size() > 0) void'(pq.pop_front());
    if (out_valid_o && out_ready_i) begin
      check("out_busy", {31'd0, busy_o}, 32'd1);
      fout_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %0h, expected no output", out_data_o);
      end else begin
        e = sb.pop_front();
        check("out_data", {24'd0, out_data_o}, {24'd0, e[7:0]});
        check("out_owner", {31'd0, out_owner_o}, {31'd0, e[8]});
      end
    end
    if (prev_fd) check("frame_done_pulse", {31'd0, frame_done_o}, 32'd0);
    if (frame_done_o) begin
      check("frame_in_beats", fin_cnt, 32'd16);
      check("frame_out_beats", fout_cnt, 32'd4);
      check("busy_after_done", {31'd0, busy_o}, 32'd0);
      check("overrun_at_done", {31'd0, overrun_o}, {31'd0, exp_ovr});
      if (done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame_done: got owner %0d, expected none", done_owner_o);
      end else begin
        check("done_owner", {31'd0, done_owner_o}, {31'd0, done_q.pop_front()});
      end
      fin_cnt  = 0;
      fout_cnt = 0;
    end
    prev_fd = frame_done_o;
    @(posedge clk_i);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_frames(input int budget, input string name);
    int n;
    n = 0;
    while ((done_q.size() > 0 || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (done_q.size() > 0 || sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d frames pending, expected 0", name, done_q.size());
    end
  endtask

  task automatic apply_reset();
    reset_ni  = 1'b0;
    rq0.delete();
    rq1.delete();
    sb.delete();
    done_q.delete();
    pq.delete();
    pcnt      = 0;
    fin_cnt   = 0;
    fout_cnt  = 0;
    prev_fd   = 1'b0;
    gap_en    = 1'b0;
    tog_en    = 1'b0;
    pov_force = 1'b0;
    exp_ovr   = 1'b0;
    drive();
    @(posedge clk_i);
    #1;
  endtask

  task automatic release_reset();
    reset_ni = 1'b1;
    drive();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ftab[0] = '{r: 1'b0, gap: 1'b0, tog: 1'b0, pix: F0, ex: E0};
    ftab[1] = '{r: 1'b0, gap: 1'b1, tog: 1'b1, pix: F1, ex: E1};
    ftab[2] = '{r: 1'b1, gap: 1'b0, tog: 1'b0, pix: F2, ex: E2};
    ftab[3] = '{r: 1'b1, gap: 1'b1, tog: 1'b1, pix: F3, ex: E3};

    itab[0] = '{rv: 2'b11, pir: 1'b1, pov: 1'b1, ordy: 1'b1, ex: 6'd0};
    itab[1] = '{rv: 2'b01, pir: 1'b1, pov: 1'b0, ordy: 1'b1, ex: 6'd0};
    itab[2] = '{rv: 2'b10, pir: 1'b0, pov: 1'b1, ordy: 1'b0, ex: 6'd0};
    itab[3] = '{rv: 2'b00, pir: 1'b1, pov: 1'b1, ordy: 1'b1, ex: 6'd0};

    reset_ni = 1'b0;
    apply_reset();

    // Outputs while held in reset, whatever the inputs.
    for (int i = 0; i < 4; i++) begin
      req_valid_i      = itab[i].rv;
      req_data_i       = {8'hA5, 8'h5A};
      pool_in_ready_i  = itab[i].pir;
      pool_out_valid_i = itab[i].pov;
      pool_out_data_i  = 8'h77;
      out_ready_i      = itab[i].ordy;
      #1;
      check("reset_outputs",
            {26'd0, req_ready_o, pool_in_valid_o, pool_out_ready_o, out_valid_o, busy_o},
            {26'd0, itab[i].ex});
    end
    drive();
    release_reset();
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
    check("rst_done_owner", {31'd0, done_owner_o}, 32'd0);
    check("rst_overrun", {31'd0, overrun_o}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);

    // Single-requester frames, including gappy inputs and toggling out_ready.
    for (int t = 0; t < 4; t++) begin
      gap_en = ftab[t].gap;
      tog_en = ftab[t].tog;
      load(ftab[t].r, ftab[t].pix, ftab[t].ex);
      drive();
      run_frames(200, "table_frame");
    end
    gap_en = 1'b0;
    tog_en = 1'b0;

    // Last frame was requester 1, so requester 0 must win the next tie.
    load(1'b0, F1, E1);
    load(1'b1, F0, E0);
    drive();
    run_frames(300, "prio_after_r1");

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    apply_reset();
    load(1'b0, F0, E0);
    load(1'b1, F1, E1);
    load(1'b0, F2, E2);
    load(1'b1, F3, E3);
    release_reset();
    run_frames(600, "alternate");

    // Reset mid-frame after six accepted inputs.
    apply_reset();
    load(1'b0, F0, E0);
    release_reset();
    for (int n = 0; n < 100 && fin_cnt < 6; n++) step();
    check("mid_reset_inputs", fin_cnt, 32'd6);
    check("mid_busy_before", {31'd0, busy_o}, 32'd1);
    reset_ni = 1'b0;
    #1;
    check("mid_reset_busy", {31'd0, busy_o}, 32'd0);
    check("mid_reset_strobes",
          {27'd0, req_ready_o, pool_in_valid_o, pool_out_ready_o, out_valid_o},
          32'd0);
    apply_reset();
    load(1'b0, F3, E3);
    release_reset();
    run_frames(200, "after_mid_reset");

    // Pool result while idle: flagged, not forwarded, sticky until reset.
    pov_force = 1'b1;
    drive();
    #1;
    check("idle_pov_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("idle_pov_ready", {31'd0, pool_out_ready_o}, 32'd0);
    step();
    check("overrun_set", {31'd0, overrun_o}, 32'd1);
    pov_force = 1'b0;
    exp_ovr   = 1'b1;
    load(1'b0, F1, E1);
    drive();
    run_frames(200, "after_overrun");
    check("overrun_sticky", {31'd0, overrun_o}, 32'd1);
    apply_reset();
    #1;
    check("overrun_cleared", {31'd0, overrun_o}, 32'd0);
    release_reset();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool_scheduler.md
POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 Parameter IMAGE_HEIGHT, default 4, input frame rows.
REQ-002 Parameter IMAGE_WIDTH, default 4, input frame columns.
REQ-003 Parameter ROW_STRIDE, default 2, pooling row stride.
REQ-004 Parameter COL_STRIDE, default 2, pooling column stride.
REQ-005 Derived constants SHALL be IN_BEATS = IMAGE_HEIGHT*IMAGE_WIDTH and OUT_BEATS = (IMAGE_HEIGHT/ROW_STRIDE)*(IMAGE_WIDTH/COL_STRIDE).
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 req_valid[2]  in  1 each  requester has a pixel beat.
REQ-010 req_ready[2]  out  1 each  requester beat accepted.
REQ-011 req_data[2]  in  feature_type each  requester pixel.
REQ-012 pool_in_valid  out  1  beat to the shared max-pool unit.
REQ-013 pool_in_ready  in  1  max-pool unit accepts the beat.
REQ-014 pool_in_data  out  feature_type  pixel to the max-pool unit.
REQ-015 pool_out_valid  in  1  max-pool result valid.
REQ-016 pool_out_ready  out  1  result accepted.
REQ-017 pool_out_data  in  feature_type  max-pool result.
REQ-018 out_valid / out_ready / out_data  out / in / out  1 / 1 / feature_type  result stream to the consumer.
REQ-019 out_owner  out  1  requester index of the current result.
REQ-020 busy  out  1  frame in progress (state != IDLE).
REQ-021 frame_done  out  1  single-cycle pulse at frame completion.
REQ-022 done_owner  out  1  requester index of the completed frame, held until the next frame_done.
REQ-023 overrun  out  1  sticky protocol-error flag.

Function
REQ-024 The block SHALL time-share one max-pool unit between two requesters at frame granularity, with states IDLE, FEED and DRAIN.
REQ-025 IDLE: req_ready=0, pool_in_valid=0, pool_out_ready=0, out_valid=0.
REQ-026 IDLE grant: on any clock edge with any req_valid, the block SHALL register owner = prio if req_valid[prio], else the other requester, and go to FEED; no beat transfers in IDLE.
REQ-027 FEED: pool_in_valid=req_valid[owner], pool_in_data=req_data[owner], req_ready[owner]=pool_in_ready, and req_ready of the non-owner SHALL be 0.
REQ-028 The input counter SHALL increment on each pool_in_valid&&pool_in_ready; the handshake that completes beat IN_BEATS SHALL move FEED to DRAIN.
REQ-029 In FEED and DRAIN the result path SHALL be combinational: out_valid=pool_out_valid, out_data=pool_out_data, pool_out_ready=out_ready, out_owner=owner.
REQ-030 The output counter SHALL increment on each out_valid&&out_ready in FEED or DRAIN.
REQ-031 A frame SHALL complete on the edge where both counters reach their totals, whichever finishes last, including a same-cycle finish.
REQ-032 On completion the block SHALL go to IDLE, clear both counters, set prio = ~owner, pulse frame_done for the following cycle, and set done_owner = owner.
REQ-033 Output beats beyond OUT_BEATS SHALL be impossible: once the output count is complete, pool_out_ready and out_valid SHALL be 0.
REQ-034 pool_out_valid while in IDLE, or after the output count is complete, SHALL set overrun=1; the beat is not forwarded.
REQ-035 Requester deassertion of req_valid mid-frame SHALL stall the frame without releasing the grant.
REQ-036 Counters SHALL be $clog2(IN_BEATS+1) and $clog2(OUT_BEATS+1) bits wide.

Reset
REQ-037 Asserting reset_n low at any time SHALL immediately force state IDLE, both counters 0, prio=0, owner=0, done_owner=0, frame_done=0, overrun=0, and all valid/ready outputs to 0.
REQ-038 After reset release, a partially fed frame SHALL be discarded, and the next grant SHALL restart at input beat 0.

Verification
REQ-039 Requester 0 alone sends 8,1,5,3,6,7,2,4,9,0,3,2,1,5,6,8 with out_ready=1 -> outputs 8,5,9,8, out_owner=0, exactly one frame_done, done_owner=0.
REQ-040 Both requesters hold req_valid from reset, for three frames -> grants in order 0,1,0, and the non-owner req_ready is never 1.
REQ-041 Only requester 1 is valid while prio=0 -> requester 1 is granted, and after completion prio=0.
REQ-042 out_ready toggles 1,0,1,0 and req_valid has gaps -> exactly 16 inputs and 4 outputs, no beat lost or duplicated, busy high until completion.
REQ-043 reset_n is pulsed low after 6 accepted inputs -> IDLE and all outputs 0 immediately; the next frame accepts a full 16 beats.
REQ-044 pool_out_valid=1 while in IDLE -> overrun=1 and out_valid=0; overrun stays 1 until reset.
